// File: rtl/cnt_chk_pkg.sv
// Shared types and default parameters for the count-sequence checker.
// No logic and no flow control; used only at elaboration.
package cnt_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int DEF_WIDTH    = 3;
    localparam int DEF_LOCK_CNT = 2;
    localparam int DEF_ERR_W    = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, which takes priority over increment.
// Value visible the cycle after inc_i; no backpressure, increments at the maximum are dropped.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/count_seq_checker.sv
// Checks a wrapping counter stream for +1 steps; locks after LOCK_CNT good steps, counts locked errors.
// All outputs registered, one cycle after the sample; no backpressure. CNT_CHK_STICKY_EN enables err_sticky.
module count_seq_checker
    import cnt_chk_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] expected,
    output logic             err_sticky
);

    localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);

    state_e           state_q;
    logic [3:0]       run_q;
    logic [WIDTH-1:0] expected_q;
    logic             locked_q;
    logic             err_pulse_q;

    logic             match;
    logic             err_hit;
    logic [WIDTH-1:0] next_val;
    logic [3:0]       run_inc;

    assign match    = (in_data == expected_q);
    assign next_val = in_data + WIDTH'(1);
    assign run_inc  = run_q + 4'd1;
    assign err_hit  = in_valid && (state_q == LOCKED) && !match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            run_q       <= 4'd0;
            expected_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (in_valid) begin
                // Every sample reseeds the expectation, so a mismatch resyncs to the new value.
                expected_q <= next_val;
                case (state_q)
                    IDLE: begin
                        run_q   <= 4'd0;
                        state_q <= SYNC;
                    end
                    SYNC: begin
                        if (match) begin
                            run_q <= run_inc;
                            if (run_inc == LOCK_V) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            run_q <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (!match) begin
                            err_pulse_q <= 1'b1;
                            run_q       <= 4'd0;
                            state_q     <= SYNC;
                            locked_q    <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (err_hit),
        .cnt_o (err_cnt)
    );

`ifdef CNT_CHK_STICKY_EN
    logic sticky_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (err_hit) begin
            sticky_q <= 1'b1;
        end
    end

    assign err_sticky = sticky_q;
`else
    assign err_sticky = 1'b0;
`endif

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign expected  = expected_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: default build plus an ERR_W=2 copy driven by the same stream.
module tb_count_seq_checker;

`ifdef CNT_CHK_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    typedef struct {
        bit lk;
        bit pl;
        int ec;
        int ex;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_data = 3'd0;

    logic       a_locked, a_pulse, a_sticky;
    logic [7:0] a_cnt;
    logic [2:0] a_exp;
    logic       b_locked, b_pulse, b_sticky;
    logic [1:0] b_cnt;
    logic [2:0] b_exp;

    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;
    exp_t q[$];
    exp_t mon_e;

    count_seq_checker #(.WIDTH(3), .LOCK_CNT(2), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .locked(a_locked), .err_pulse(a_pulse), .err_cnt(a_cnt),
        .expected(a_exp), .err_sticky(a_sticky)
    );

    count_seq_checker #(.WIDTH(3), .LOCK_CNT(2), .ERR_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .locked(b_locked), .err_pulse(b_pulse), .err_cnt(b_cnt),
        .expected(b_exp), .err_sticky(b_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " locked"},     int'(a_locked), 0);
        chk({tag, " err_pulse"},  int'(a_pulse),  0);
        chk({tag, " err_cnt"},    int'(a_cnt),    0);
        chk({tag, " expected"},   int'(a_exp),    0);
        chk({tag, " err_sticky"}, int'(a_sticky), 0);
        chk({tag, " w2 err_cnt"}, int'(b_cnt),    0);
        chk({tag, " w2 sticky"},  int'(b_sticky), 0);
    endtask

    // Drive one cycle of input and queue the outputs expected after the next edge.
    task automatic step(input bit v, input int d, input bit lk, input bit pl,
                        input int ec, input int ex);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_data  = 3'(d);
        e.lk = lk; e.pl = pl; e.ec = ec; e.ex = ex;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        #2;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("locked",     int'(a_locked), int'(mon_e.lk));
            chk("err_pulse",  int'(a_pulse),  int'(mon_e.pl));
            chk("err_cnt",    int'(a_cnt),    mon_e.ec);
            chk("expected",   int'(a_exp),    mon_e.ex);
            chk("err_sticky", int'(a_sticky), (STICKY_ON && mon_e.ec > 0) ? 1 : 0);
            chk("w2 err_pulse", int'(b_pulse), int'(mon_e.pl));
            chk("w2 err_cnt",  int'(b_cnt),   (mon_e.ec > 3) ? 3 : mon_e.ec);
            chk("w2 locked",   int'(b_locked), int'(mon_e.lk));
            if (b_pulse) pulse_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #2 chk_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        // Acquire lock on 0,1,2
        step(1, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 2);
        step(1, 2, 1, 0, 0, 3);
        // Locked run through the 7 -> 0 wrap
        step(1, 3, 1, 0, 0, 4);
        step(1, 4, 1, 0, 0, 5);
        step(1, 5, 1, 0, 0, 6);
        step(1, 6, 1, 0, 0, 7);
        step(1, 7, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 1);
        step(1, 1, 1, 0, 0, 2);
        step(1, 2, 1, 0, 0, 3);
        step(1, 3, 1, 0, 0, 4);
        // Locked mismatch at expected=4, then relock on 7,0
        step(1, 6, 0, 1, 1, 7);
        step(1, 7, 0, 0, 1, 0);
        step(1, 0, 1, 0, 1, 1);
        // Error, resync on 3, gap of 4 idle cycles, relock on 4
        step(1, 2, 0, 1, 2, 3);
        step(1, 3, 0, 0, 2, 4);
        for (int i = 0; i < 4; i++) step(0, 7, 0, 0, 2, 4);
        step(1, 4, 1, 0, 2, 5);
        step(1, 5, 1, 0, 2, 6);
        // Error, then mismatch on the would-lock sample and a back-to-back SYNC mismatch
        step(1, 0, 0, 1, 3, 1);
        step(1, 1, 0, 0, 3, 2);
        step(1, 5, 0, 0, 3, 6);
        step(1, 0, 0, 0, 3, 1);
        step(1, 1, 0, 0, 3, 2);
        step(1, 2, 1, 0, 3, 3);
        // Two more locked errors: w2 counter saturates at 3
        step(1, 7, 0, 1, 4, 0);
        step(1, 0, 0, 0, 4, 1);
        step(1, 1, 1, 0, 4, 2);
        step(1, 4, 0, 1, 5, 5);
        step(1, 5, 0, 0, 5, 6);
        step(1, 6, 1, 0, 5, 7);
        step(0, 0, 1, 0, 5, 7);

        // Asynchronous reset between edges while locked with err_cnt=5
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_all_zero("async reset");
        chk("pulse count", pulse_cnt, 5);
        @(negedge clk) rst = 1'b0;

        // First sample after reset only seeds the expectation
        step(1, 5, 0, 0, 0, 6);
        step(1, 6, 0, 0, 0, 7);
        step(1, 7, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);

        @(posedge clk);
        #4;
        chk("queue drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
